// File: rtl/uart_pkg.sv
// Shared UART constants: default receiver word width, RX FIFO address width,
// baud divisor width and the receiver oversampling factor.
package uart_pkg;

  localparam int unsigned DefDbits   = 8;
  localparam int unsigned DefFifoAw  = 2;
  localparam int unsigned DefDvsrW   = 11;
  // Receiver samples each bit this many times; dvsr = f_clk / (Oversample * baud) - 1.
  localparam int unsigned Oversample = 16;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO, depth 2**FIFO_AW.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers only)
//   wr, wdata     push request and data; accepted when not full, or when full
//                 and a pop is accepted in the same cycle
//   rd            pop request; ignored while empty
//   rdata         head word, combinational from storage
//   empty, full   occupancy flags derived from the pointers
module fifo_sync
  import uart_pkg::*;
#(
  parameter int unsigned DBITS   = DefDbits,
  parameter int unsigned FIFO_AW = DefFifoAw
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [DBITS-1:0] wdata,
  input  logic             rd,
  output logic [DBITS-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  logic [DBITS-1:0] mem_q [Depth];
  // Extra MSB is a wrap bit that separates full from empty.
  logic [FIFO_AW:0] wptr_q, rptr_q;
  logic             wr_en, rd_en;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
            (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    rd_en = rd & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    wr_en = wr & (~full | rd_en);
    rdata = mem_q[rptr_q[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (FIFO_AW+1)'(1);
      if (rd_en) rptr_q <= rptr_q + (FIFO_AW+1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wptr_q[FIFO_AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: 16x oversampling tick generator plus an RX
// FIFO that captures each completed byte from the receiver.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   dvsr           baud divisor; s_tick period is dvsr+1 clocks
//   s_tick         registered one-cycle oversampling tick to the receiver
//   rx_done        receiver byte-complete pulse, rx_data valid with it
//   rd             pop request from the bus side
//   rd_data        FIFO head word (first-word fall-through)
//   rx_empty       FIFO empty
//   rx_full        FIFO full
//   overrun        sticky: a byte was dropped because the FIFO was full
//   clr_overrun    clears overrun (a same-cycle drop wins)
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DBITS   = DefDbits,
  parameter int unsigned FIFO_AW = DefFifoAw,
  parameter int unsigned DVSR_W  = DefDvsrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              s_tick,
  input  logic              rx_done,
  input  logic [DBITS-1:0]  rx_data,
  input  logic              rd,
  output logic [DBITS-1:0]  rd_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              overrun,
  input  logic              clr_overrun
);

  logic [DVSR_W-1:0] tcnt_q;
  logic              s_tick_q;
  logic              overrun_q;
  logic              drop;

  // Tick generator. The >= compare lets a lowered dvsr wrap immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q   <= '0;
      s_tick_q <= 1'b0;
    end else if (tcnt_q >= dvsr) begin
      tcnt_q   <= '0;
      s_tick_q <= 1'b1;
    end else begin
      tcnt_q   <= tcnt_q + DVSR_W'(1);
      s_tick_q <= 1'b0;
    end
  end

  fifo_sync #(
    .DBITS   (DBITS),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (rx_done),
    .wdata (rx_data),
    .rd    (rd),
    .rdata (rd_data),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // A full FIFO is never empty, so any rd frees a slot for the push.
  assign drop = rx_done & rx_full & ~rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  assign s_tick  = s_tick_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: expected bytes are queued when pushed
// and compared against rd_data when popped.
module tb_uart_rx_ctrl;

  localparam int unsigned DBITS   = 8;
  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned DVSR_W  = 11;
  localparam int unsigned DEPTH   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DVSR_W-1:0] dvsr;
  logic              s_tick;
  logic              rx_done;
  logic [DBITS-1:0]  rx_data;
  logic              rd;
  logic [DBITS-1:0]  rd_data;
  logic              rx_empty;
  logic              rx_full;
  logic              overrun;
  logic              clr_overrun;

  int n_total = 0;
  int n_bad   = 0;

  logic [DBITS-1:0] sb [$];
  logic             exp_ovr;

  uart_rx_ctrl #(
    .DBITS   (DBITS),
    .FIFO_AW (FIFO_AW),
    .DVSR_W  (DVSR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dvsr        (dvsr),
    .s_tick      (s_tick),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .rd          (rd),
    .rd_data     (rd_data),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of FIFO traffic, with the scoreboard updated alongside.
  task automatic cycle(input logic w, input logic [DBITS-1:0] d, input logic r, input logic c);
    logic rd_ok;
    logic set;
    rd_ok = r && (sb.size() > 0);
    set   = 1'b0;
    if (rd_ok) begin
      check_eq("rd_data", 32'(rd_data), 32'(sb[0]));
      void'(sb.pop_front());
    end
    if (w) begin
      if (sb.size() < DEPTH) sb.push_back(d);
      else set = 1'b1;
    end
    if (set) exp_ovr = 1'b1;
    else if (c) exp_ovr = 1'b0;
    rx_done = w; rx_data = d; rd = r; clr_overrun = c;
    step();
    rx_done = 1'b0; rd = 1'b0; clr_overrun = 1'b0;
    check_eq("rx_empty", 32'(rx_empty), 32'(sb.size() == 0));
    check_eq("rx_full", 32'(rx_full), 32'(sb.size() == DEPTH));
    check_eq("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    rst = 1'b1; dvsr = DVSR_W'(3); rx_done = 1'b0; rx_data = '0;
    rd = 1'b0; clr_overrun = 1'b0; exp_ovr = 1'b0;
    step();
    check_eq("rst_s_tick", 32'(s_tick), 32'd0);
    check_eq("rst_empty", 32'(rx_empty), 32'd1);
    check_eq("rst_full", 32'(rx_full), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);

    // Tick: dvsr=3 -> ticks at cycles 4, 8, 12; tcnt is 2 after cycle 14.
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k <= 12) check_eq("tick_d3", 32'(s_tick), 32'((k % 4) == 0));
    end
    dvsr = DVSR_W'(1);
    for (int k = 15; k <= 20; k++) begin
      step();
      check_eq("tick_d1", 32'(s_tick), 32'((k % 2) == 1));
    end

    // Two pushes, two pops.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill, drop a fifth, drain, clear.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous push and pop: no drop, 0x77 read last.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Drop wins over clear; clear alone then works.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // Pop on empty is ignored; push+pop on empty keeps the push only.
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-operation: 3 words queued, overrun set, tick mid-count.
    dvsr = DVSR_W'(3);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    rst = 1'b1; rx_done = 1'b1; rx_data = 8'hEE;
    step();
    rst = 1'b0; rx_done = 1'b0;
    sb.delete();
    exp_ovr = 1'b0;
    check_eq("mid_rst_empty", 32'(rx_empty), 32'd1);
    check_eq("mid_rst_full", 32'(rx_full), 32'd0);
    check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
    check_eq("mid_rst_s_tick", 32'(s_tick), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq("tick_after_rst", 32'(s_tick), 32'((k % 4) == 0));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
